// File: rtl/core_pkg.sv
// Shared encodings and lane helpers for the memory pipeline stage.
package core_pkg;

    // Writeback result source selector
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Misaligned access or funct3 that is not a legal access for its direction
    function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic fault;
        case (f3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = lo[0];
            F3_W:    fault = (lo != 2'b00);
            F3_BU:   fault = is_store;
            F3_HU:   fault = is_store | lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

    // Byte enables for the addressed lane(s)
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << lo;
            F3_H, F3_HU: be = 4'b0011 << lo;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data so every lane carries the right bytes
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] lanes;
        case (f3)
            F3_B:    lanes = {4{data[7:0]}};
            F3_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/stage_memory_load_align.sv
// Extracts the addressed byte/halfword of a load response and extends it.
module load_align
    import core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the low address bits
    always_comb begin
        byte_s = 8'h00;
        case (addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign or zero extension by access type
    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{byte_s[7]}}, byte_s};
            F3_BU:   result = {24'h000000, byte_s};
            F3_H:    result = {{16{half_s[15]}}, half_s};
            F3_HU:   result = {16'h0000, half_s};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: RV32I loads/stores over a valid/ready bus,
// pass-through for non-memory results, single registered writeback result.
module stage_memory
    import core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              execute_valid,
    input  logic [4:0]        execute_rd,
    input  logic              execute_wr_enable,
    input  logic [1:0]        execute_result_src,
    input  logic              execute_mem_write,
    input  logic [2:0]        execute_funct3,
    input  logic [XLEN-1:0]   execute_alu_result,
    input  logic [XLEN-1:0]   execute_store_data,
    input  logic [XLEN-1:0]   execute_instr_addr_plus,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [3:0]        dmem_req_be,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_rdata,
    output logic              memory_valid,
    output logic [4:0]        memory_rd,
    output logic              memory_wr_enable,
    output logic [XLEN-1:0]   memory_result,
    output logic              memory_misaligned,
    output logic              memory_stall
);

    mem_state_t        state_r;
    logic              req_valid_r;
    logic              req_we_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [XLEN-1:0]   req_wdata_r;
    logic [3:0]        req_be_r;
    logic [2:0]        funct3_r;
    logic [1:0]        addr_lo_r;
    logic [4:0]        rd_r;
    logic              wr_en_r;
    logic              mem_valid_r;
    logic [4:0]        mem_rd_r;
    logic              mem_wr_enable_r;
    logic [XLEN-1:0]   mem_result_r;
    logic              mem_misaligned_r;

    logic              is_mem_s;
    logic              fault_s;
    logic [XLEN-1:0]   load_value_s;

    // Classify the incoming execute instruction
    always_comb begin
        is_mem_s = execute_mem_write | (execute_result_src == RES_MEM);
        fault_s  = access_fault(execute_mem_write, execute_funct3, execute_alu_result[1:0]);
    end

    load_align u_load_align (
        .rdata  (dmem_rsp_rdata),
        .addr   (addr_lo_r),
        .funct3 (funct3_r),
        .result (load_value_s)
    );

    // Transaction FSM with registered bus and writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            req_valid_r      <= 1'b0;
            req_we_r         <= 1'b0;
            req_addr_r       <= '0;
            req_wdata_r      <= '0;
            req_be_r         <= 4'b0000;
            funct3_r         <= 3'b000;
            addr_lo_r        <= 2'b00;
            rd_r             <= 5'd0;
            wr_en_r          <= 1'b0;
            mem_valid_r      <= 1'b0;
            mem_rd_r         <= 5'd0;
            mem_wr_enable_r  <= 1'b0;
            mem_result_r     <= '0;
            mem_misaligned_r <= 1'b0;
        end else begin
            // writeback strobes are single-cycle pulses
            mem_valid_r      <= 1'b0;
            mem_wr_enable_r  <= 1'b0;
            mem_misaligned_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (execute_valid) begin
                        if (!is_mem_s) begin
                            mem_valid_r     <= 1'b1;
                            mem_rd_r        <= execute_rd;
                            mem_wr_enable_r <= execute_wr_enable;
                            if (execute_result_src == RES_PC4) begin
                                mem_result_r <= execute_instr_addr_plus;
                            end else begin
                                mem_result_r <= execute_alu_result;
                            end
                        end else if (fault_s) begin
                            // trap: retire without touching the bus
                            mem_valid_r      <= 1'b1;
                            mem_misaligned_r <= 1'b1;
                            mem_rd_r         <= execute_rd;
                            mem_result_r     <= '0;
                        end else begin
                            state_r     <= REQ;
                            req_valid_r <= 1'b1;
                            req_we_r    <= execute_mem_write;
                            req_addr_r  <= {execute_alu_result[ADDR_W-1:2], 2'b00};
                            req_be_r    <= byte_enable(execute_funct3, execute_alu_result[1:0]);
                            req_wdata_r <= store_lanes(execute_funct3, execute_store_data);
                            funct3_r    <= execute_funct3;
                            addr_lo_r   <= execute_alu_result[1:0];
                            rd_r        <= execute_rd;
                            wr_en_r     <= execute_wr_enable & ~execute_mem_write;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        req_valid_r <= 1'b0;
                        if (req_we_r) begin
                            state_r     <= DONE;
                            mem_valid_r <= 1'b1;
                            mem_rd_r    <= rd_r;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        state_r         <= DONE;
                        mem_valid_r     <= 1'b1;
                        mem_rd_r        <= rd_r;
                        mem_wr_enable_r <= wr_en_r;
                        mem_result_r    <= load_value_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Stall is a pure function of the state
    always_comb begin
        if (state_r != IDLE) begin
            memory_stall = 1'b1;
        end else begin
            memory_stall = 1'b0;
        end
    end

    assign dmem_req_valid    = req_valid_r;
    assign dmem_req_we       = req_we_r;
    assign dmem_req_addr     = req_addr_r;
    assign dmem_req_wdata    = req_wdata_r;
    assign dmem_req_be       = req_be_r;
    assign memory_valid      = mem_valid_r;
    assign memory_rd         = mem_rd_r;
    assign memory_wr_enable  = mem_wr_enable_r;
    assign memory_result     = mem_result_r;
    assign memory_misaligned = mem_misaligned_r;

endmodule

// File: tb/tb_stage_memory.sv
// Directed, table-driven bench for stage_memory.
module tb_stage_memory;

    logic        clk;
    logic        rst_n;
    logic        execute_valid;
    logic [4:0]  execute_rd;
    logic        execute_wr_enable;
    logic [1:0]  execute_result_src;
    logic        execute_mem_write;
    logic [2:0]  execute_funct3;
    logic [31:0] execute_alu_result;
    logic [31:0] execute_store_data;
    logic [31:0] execute_instr_addr_plus;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        memory_valid;
    logic [4:0]  memory_rd;
    logic        memory_wr_enable;
    logic [31:0] memory_result;
    logic        memory_misaligned;
    logic        memory_stall;

    int errors = 0;
    int checks = 0;

    stage_memory #(.ADDR_W(32), .XLEN(32)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .execute_valid           (execute_valid),
        .execute_rd              (execute_rd),
        .execute_wr_enable       (execute_wr_enable),
        .execute_result_src      (execute_result_src),
        .execute_mem_write       (execute_mem_write),
        .execute_funct3          (execute_funct3),
        .execute_alu_result      (execute_alu_result),
        .execute_store_data      (execute_store_data),
        .execute_instr_addr_plus (execute_instr_addr_plus),
        .dmem_req_valid          (dmem_req_valid),
        .dmem_req_ready          (dmem_req_ready),
        .dmem_req_we             (dmem_req_we),
        .dmem_req_addr           (dmem_req_addr),
        .dmem_req_wdata          (dmem_req_wdata),
        .dmem_req_be             (dmem_req_be),
        .dmem_rsp_valid          (dmem_rsp_valid),
        .dmem_rsp_rdata          (dmem_rsp_rdata),
        .memory_valid            (memory_valid),
        .memory_rd               (memory_rd),
        .memory_wr_enable        (memory_wr_enable),
        .memory_result           (memory_result),
        .memory_misaligned       (memory_misaligned),
        .memory_stall            (memory_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 pass-through, 1 fault, 2 bus transaction
    typedef struct packed {
        logic [1:0]  src;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] plus;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wr;
        logic [1:0]  kind;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
        logic        wr_out;
    } vec_t;

    vec_t vecs [15];

    logic [31:0] log_q [$];
    bit          log_en = 1'b0;

    // Record the result of every retired instruction while logging is on
    always @(negedge clk) begin
        if (log_en && memory_valid) log_q.push_back(memory_result);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        execute_result_src      = v.src;
        execute_mem_write       = v.mw;
        execute_funct3          = v.f3;
        execute_alu_result      = v.alu;
        execute_store_data      = v.sdata;
        execute_instr_addr_plus = v.plus;
        execute_rd              = v.rd;
        execute_wr_enable       = v.wr;
    endtask

    // Issue one instruction, serve the bus with minimum latency, check everything
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v);
        execute_valid = 1'b1;
        @(posedge clk); #1;
        execute_valid = 1'b0;
        if (v.kind != 2'd2) begin
            chk({t, "_valid"}, 32'(memory_valid), 32'd1);
            chk({t, "_misal"}, 32'(memory_misaligned), (v.kind == 2'd1) ? 32'd1 : 32'd0);
            chk({t, "_wren"}, 32'(memory_wr_enable), 32'(v.wr_out));
            chk({t, "_noreq"}, 32'(dmem_req_valid), 32'd0);
            chk({t, "_stall"}, 32'(memory_stall), 32'd0);
            chk({t, "_rd"}, 32'(memory_rd), 32'(v.rd));
            if (v.kind == 2'd0) chk({t, "_result"}, memory_result, v.result);
        end else begin
            chk({t, "_reqv"}, 32'(dmem_req_valid), 32'd1);
            chk({t, "_we"}, 32'(dmem_req_we), 32'(v.mw));
            chk({t, "_addr"}, dmem_req_addr, v.addr);
            chk({t, "_be"}, 32'(dmem_req_be), 32'(v.be));
            if (v.mw) chk({t, "_wdata"}, dmem_req_wdata, v.wdata);
            chk({t, "_stall"}, 32'(memory_stall), 32'd1);
            dmem_req_ready = 1'b1;
            @(posedge clk); #1;
            dmem_req_ready = 1'b0;
            chk({t, "_reqdrop"}, 32'(dmem_req_valid), 32'd0);
            if (!v.mw) begin
                chk({t, "_early"}, 32'(memory_valid), 32'd0);
                dmem_rsp_valid = 1'b1;
                dmem_rsp_rdata = v.rdata;
                @(posedge clk); #1;
                dmem_rsp_valid = 1'b0;
                chk({t, "_result"}, memory_result, v.result);
            end
            chk({t, "_valid"}, 32'(memory_valid), 32'd1);
            chk({t, "_wren"}, 32'(memory_wr_enable), 32'(v.wr_out));
            chk({t, "_rd"}, 32'(memory_rd), 32'(v.rd));
            @(posedge clk); #1;
            chk({t, "_idle"}, 32'(memory_stall), 32'd0);
            chk({t, "_pulse"}, 32'(memory_valid), 32'd0);
        end
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t sh;
        //         src    mw    f3      alu            sdata          plus           rdata          rd     wr    kind   be        addr           wdata          result         wr_out
        vecs[0]  = '{2'b00, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,         32'h0,         5'd5,  1'b1, 2'd0, 4'b0000, 32'h0,         32'h0,         32'h0000_1234, 1'b1};
        vecs[1]  = '{2'b11, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0,        32'h0,         32'h0,         5'd7,  1'b1, 2'd0, 4'b0000, 32'h0,         32'h0,         32'hCAFE_0001, 1'b1};
        vecs[2]  = '{2'b10, 1'b0, 3'b000, 32'h0000_0055, 32'h0,        32'h0000_0200, 32'h0,         5'd1,  1'b1, 2'd0, 4'b0000, 32'h0,         32'h0,         32'h0000_0200, 1'b1};
        vecs[3]  = '{2'b01, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h0,         32'h80FF_0000, 5'd10, 1'b1, 2'd2, 4'b1000, 32'h0000_1000, 32'h0,         32'hFFFF_FF80, 1'b1};
        vecs[4]  = '{2'b01, 1'b0, 3'b100, 32'h0000_1001, 32'h0,        32'h0,         32'h1234_80AB, 5'd11, 1'b1, 2'd2, 4'b0010, 32'h0000_1000, 32'h0,         32'h0000_0080, 1'b1};
        vecs[5]  = '{2'b01, 1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'h0,         32'h8001_0000, 5'd12, 1'b1, 2'd2, 4'b1100, 32'h0000_1000, 32'h0,         32'hFFFF_8001, 1'b1};
        vecs[6]  = '{2'b01, 1'b0, 3'b010, 32'h0000_1004, 32'h0,        32'h0,         32'hDEAD_BEEF, 5'd13, 1'b1, 2'd2, 4'b1111, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{2'b01, 1'b0, 3'b101, 32'h0000_1000, 32'h0,        32'h0,         32'h1111_F00D, 5'd14, 1'b1, 2'd2, 4'b0011, 32'h0000_1000, 32'h0,         32'h0000_F00D, 1'b1};
        vecs[8]  = '{2'b00, 1'b1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 32'h0,        32'h0,         5'd0,  1'b0, 2'd2, 4'b0010, 32'h0000_2000, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[9]  = '{2'b00, 1'b1, 3'b010, 32'h0000_2008, 32'h0BAD_F00D, 32'h0,        32'h0,         5'd0,  1'b0, 2'd2, 4'b1111, 32'h0000_2008, 32'h0BAD_F00D, 32'h0,         1'b0};
        vecs[10] = '{2'b01, 1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         32'h0,         5'd3,  1'b1, 2'd1, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0};
        vecs[11] = '{2'b00, 1'b1, 3'b001, 32'h0000_3003, 32'h0,        32'h0,         32'h0,         5'd0,  1'b0, 2'd1, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0};
        vecs[12] = '{2'b01, 1'b0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,         32'h0,         5'd4,  1'b1, 2'd1, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0};
        vecs[13] = '{2'b00, 1'b1, 3'b100, 32'h0000_3000, 32'h0,        32'h0,         32'h0,         5'd0,  1'b0, 2'd1, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0};
        vecs[14] = '{2'b01, 1'b0, 3'b001, 32'h0000_3001, 32'h0,        32'h0,         32'h0,         5'd6,  1'b1, 2'd1, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0};

        rst_n          = 1'b0;
        execute_valid  = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
        drive(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reqv", 32'(dmem_req_valid), 32'd0);
        chk("rst_valid", 32'(memory_valid), 32'd0);
        chk("rst_stall", 32'(memory_stall), 32'd0);
        chk("rst_misal", 32'(memory_misaligned), 32'd0);
        chk("rst_result", memory_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // SH with three cycles of backpressure
        sh = '{2'b00, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b0,
               2'd2, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF, 32'h0, 1'b0};
        @(negedge clk);
        drive(sh);
        execute_valid = 1'b1;
        @(posedge clk); #1;
        execute_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_reqv", c), 32'(dmem_req_valid), 32'd1);
            chk($sformatf("bp%0d_be", c), 32'(dmem_req_be), 32'hC);
            chk($sformatf("bp%0d_wdata", c), dmem_req_wdata, 32'hBEEF_BEEF);
            chk($sformatf("bp%0d_addr", c), dmem_req_addr, 32'h0000_2000);
            chk($sformatf("bp%0d_stall", c), 32'(memory_stall), 32'd1);
            @(posedge clk); #1;
        end
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        chk("bp_valid", 32'(memory_valid), 32'd1);
        chk("bp_wren", 32'(memory_wr_enable), 32'd0);
        chk("bp_stall_done", 32'(memory_stall), 32'd1);
        @(posedge clk); #1;
        chk("bp_idle", 32'(memory_stall), 32'd0);

        // LW: response during the handshake is ignored, then reset while waiting
        @(negedge clk);
        drive(vecs[6]);
        execute_valid = 1'b1;
        @(posedge clk); #1;
        execute_valid  = 1'b0;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        chk("hs_rsp_ignored", 32'(memory_valid), 32'd0);
        chk("hs_wait_stall", 32'(memory_stall), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_reqv", 32'(dmem_req_valid), 32'd0);
        chk("mid_rst_stall", 32'(memory_stall), 32'd0);
        chk("mid_rst_valid", 32'(memory_valid), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h7777_7777;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("late_rsp%0d_valid", c), 32'(memory_valid), 32'd0);
            chk($sformatf("late_rsp%0d_stall", c), 32'(memory_stall), 32'd0);
        end
        dmem_rsp_valid = 1'b0;

        // Back-to-back LHU then JAL; results must retire in order
        log_q.delete();
        log_en = 1'b1;
        run_vec(100, '{2'b01, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'h0, 32'h8001_0000, 5'd8, 1'b1,
                       2'd2, 4'b1100, 32'h0000_4000, 32'h0, 32'h0000_8001, 1'b1});
        run_vec(101, '{2'b10, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_0104, 32'h0, 5'd1, 1'b1,
                       2'd0, 4'b0000, 32'h0, 32'h0, 32'h0000_0104, 1'b1});
        @(negedge clk); #1;
        log_en = 1'b0;
        chk("order_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("order_first", log_q[0], 32'h0000_8001);
            chk("order_second", log_q[1], 32'h0000_0104);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
Pipeline stage after execute. Consumes the registered execute outputs and performs RV32I loads and stores over a valid/ready data-memory port. Non-memory results pass straight through to writeback. The block stalls the upstream pipeline while a memory transaction is outstanding, then hands a single registered result to the writeback stage.

Parameters:
ADDR_W, 32, data-bus address width
XLEN, 32, register/data width (only 32 supported)

Ports:
clk  in  1  core clock
rst_n  in  1  reset. Asynchronous, active-low; assertion is asynchronous.
execute_valid  in  1  execute outputs hold a live instruction this cycle
execute_rd  in  5  destination register
execute_wr_enable  in  1  register write requested
execute_result_src  in  2  00 ALU, 01 load data, 10 pc+4, 11 reserved (treated as ALU)
execute_mem_write  in  1  instruction is a store
execute_funct3  in  3  access size/sign (RV32I load/store funct3)
execute_alu_result  in  32  effective address, or ALU result
execute_store_data  in  32  rs2 value for stores
execute_instr_addr_plus  in  32  pc+4 for link
dmem_req_valid  out  1  bus request valid
dmem_req_ready  in  1  bus accepts request
dmem_req_we  out  1  1 store, 0 load
dmem_req_addr  out  32  word-aligned address (addr[1:0]=0)
dmem_req_wdata  out  32  store data shifted to byte lane
dmem_req_be  out  4  byte enables
dmem_rsp_valid  in  1  load response valid
dmem_rsp_rdata  in  32  load response word
memory_valid  out  1  one-cycle pulse per retired instruction
memory_rd  out  5  destination register
memory_wr_enable  out  1  writeback enable, qualified by memory_valid
memory_result  out  32  final writeback value
memory_misaligned  out  1  one-cycle exception pulse
memory_stall  out  1  upstream must hold its outputs

Behaviour:
- Reset: state IDLE. All outputs 0, including dmem_req_valid, memory_valid, memory_stall and memory_misaligned.
- memory_stall = (state != IDLE). Combinational from state only.
- The block samples execute_* only in IDLE with execute_valid=1.
- Non-memory op (result_src != 01, mem_write=0):
  - Next cycle: memory_valid=1; memory_result = alu_result (src 00/11) or instr_addr_plus (src 10).
  - Latency 1; no stall.
- Memory op in IDLE:
  - Check alignment. Misaligned if halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal funct3 (load 011/110/111, store 011-111) is flagged the same way.
  - Misaligned/illegal: no bus request. Next cycle memory_misaligned=1 and memory_valid=1 with memory_wr_enable=0. Stay IDLE.
  - Otherwise: latch address, size, sign, rd, wr_enable, lane and data; go to REQ.
- REQ:
  - dmem_req_valid=1. Request fields stay stable until dmem_req_ready.
  - On ready, a store goes to DONE and a load goes to WAIT.
- WAIT:
  - On dmem_rsp_valid, extract the lane and extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Go to DONE.
- DONE:
  - memory_valid=1 for one cycle; memory_wr_enable = latched wr_enable (stores force 0). Return to IDLE.
  - The next instruction can be sampled on the following cycle.
- Load latency: 3 cycles minimum (accept, REQ with ready=1, WAIT with rsp same cycle), then DONE. Store: 2 cycles minimum.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011 << addr[1:0], wdata = halfword replicated x2.
  - SW: be = 1111.
- Loads drive be according to size/lane as well.
- dmem_rsp_valid in any state other than WAIT is ignored, including the same cycle as the request handshake. The bus guarantees at least one cycle between accept and response.
- Reset mid-transaction: dmem_req_valid drops immediately, state goes to IDLE, and a late response is ignored.
- No request is dropped once dmem_req_valid rises, short of reset.

Decomposition:
- core_pkg holds:
  - result_src constants (RES_ALU, RES_MEM, RES_PC4);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the mem_state_t enum {IDLE, REQ, WAIT, DONE}.
- One combinational sub-module, load_align: inputs rdata, addr[1:0], funct3; output the 32-bit extended value. It is unit-testable in isolation.

Test Plan:
1. ALU pass-through: alu_result=0x0000_1234, src=00, rd=5 -> next cycle memory_valid=1, memory_result=0x1234, rd=5, stall never asserted.
2. LB sign: addr=0x1003, funct3=000, rsp_rdata=0x80FF_0000 -> be=1000, req_addr=0x1000, memory_result=0xFFFF_FF80.
3. SH lane/backpressure: addr=0x2002, store_data=0xDEAD_BEEF, ready low for 3 cycles -> req fields stable, be=1100, wdata=0xBEEF_BEEF, memory_wr_enable=0, stall high throughout.
4. Misaligned LW at 0x3001 -> no dmem_req_valid, memory_misaligned pulse 1 cycle, wr_enable=0.
5. Reset in WAIT: assert rst_n=0 after load accept, then raise rsp_valid -> outputs 0, no memory_valid pulse after reset release.
6. Back-to-back LHU at 0x4002 (rdata 0x8001_0000 -> 0x0000_8001), then a JAL (src=10, pc+4=0x104) -> two memory_valid pulses in order, results 0x8001 then 0x104.
